// File: rtl/m3ds_ahb_sram_initiator.sv
// AHB-Lite slave for the SRAM0 bank pair: zero-wait reads, writes deferred through a write buffer
// and merged byte-wise into read data until they reach the SRAM.
module m3ds_ahb_sram_initiator #(
  parameter int AW = 15
) (
  input  logic          SRAM0HCLK,
  input  logic          SRAMHRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAM0RDATA,
  output logic [AW-3:0] SRAM0ADDR,
  output logic [3:0]    SRAM0WREN,
  output logic [31:0]   SRAM0WDATA,
  output logic          SRAM0CS
);

  logic          acc, rd_a, wr_a, commit;
  logic          fill_buf, fill_stg, do_move;
  logic [3:0]    mask;
  logic [AW-3:0] haddr_w;

  logic          buf_pend, wr_dphase, rd_dphase, stg_full;
  logic [AW-3:0] buf_addr, stg_addr;
  logic [3:0]    buf_mask, stg_mask, merge_mask, merge_stg;
  logic [31:0]   buf_data, stg_data;

  logic          unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Address-phase decode is gated by reset so the SRAM port is quiet while in reset.
  assign acc     = SRAMHRESETn & HSEL & HREADY & HTRANS[1];
  assign rd_a    = acc & ~HWRITE;
  assign wr_a    = acc & HWRITE;
  assign haddr_w = HADDR[AW-1:2];

  always_comb begin
    mask = 4'b1111;
    case (HSIZE)
      3'd0:    mask = 4'b0001 << HADDR[1:0];
      3'd1:    mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  // A write's address/mask is staged until its data arrives. If the buffer is still
  // blocked by a read at that point, the staged entry keeps its data and moves into
  // the buffer on the next commit, so W,W,R sequences never lose a write.
  assign commit   = buf_pend & ~rd_a;
  assign fill_buf = wr_dphase & (~buf_pend | commit);
  assign fill_stg = wr_dphase & ~fill_buf;
  assign do_move  = commit & stg_full;

  always_ff @(posedge SRAM0HCLK or negedge SRAMHRESETn) begin
    if (!SRAMHRESETn) begin
      buf_pend   <= 1'b0;
      buf_addr   <= '0;
      buf_mask   <= '0;
      buf_data   <= '0;
      stg_full   <= 1'b0;
      stg_addr   <= '0;
      stg_mask   <= '0;
      stg_data   <= '0;
      wr_dphase  <= 1'b0;
      rd_dphase  <= 1'b0;
      merge_mask <= '0;
      merge_stg  <= '0;
    end else begin
      wr_dphase <= wr_a;
      rd_dphase <= rd_a;
      if (wr_a) begin
        stg_addr <= haddr_w;
        stg_mask <= mask;
      end
      if (fill_buf) begin
        buf_addr <= stg_addr;
        buf_mask <= stg_mask;
        buf_data <= HWDATA;
      end else if (do_move) begin
        buf_addr <= stg_addr;
        buf_mask <= stg_mask;
        buf_data <= stg_data;
      end
      buf_pend <= fill_buf | do_move | (buf_pend & ~commit);
      if (fill_stg)
        stg_data <= HWDATA;
      stg_full <= fill_stg | (stg_full & ~do_move);
      if (rd_a) begin
        // Predict where each in-flight write will sit during this read's data phase.
        if (buf_pend)
          merge_mask <= (buf_addr == haddr_w) ? buf_mask : '0;
        else
          merge_mask <= (wr_dphase && stg_addr == haddr_w) ? stg_mask : '0;
        merge_stg <= ((stg_full || (wr_dphase && buf_pend)) && stg_addr == haddr_w) ? stg_mask : '0;
      end
    end
  end

  always_comb begin
    SRAM0CS    = 1'b0;
    SRAM0WREN  = '0;
    SRAM0ADDR  = buf_addr;
    SRAM0WDATA = buf_data;
    if (rd_a) begin
      SRAM0CS   = 1'b1;
      SRAM0ADDR = haddr_w;
    end else if (commit) begin
      SRAM0CS   = 1'b1;
      SRAM0WREN = buf_mask;
    end
  end

  // The staged entry is always younger than the buffer entry, so it wins on overlap.
  always_comb begin
    HRDATA = SRAM0RDATA;
    for (int unsigned i = 0; i < 4; i++) begin
      if (rd_dphase && merge_stg[i])
        HRDATA[8*i +: 8] = stg_data[8*i +: 8];
      else if (rd_dphase && merge_mask[i])
        HRDATA[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_m3ds_ahb_sram_initiator.sv
// Scoreboard bench: bus-level memory model predicts read data; an SRAM model logs every write.
module tb_m3ds_ahb_sram_initiator;

  logic        SRAM0HCLK = 1'b0;
  logic        SRAMHRESETn;
  logic        HSEL, HWRITE, HREADY;
  logic [14:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic [31:0] SRAM0RDATA;
  logic [12:0] SRAM0ADDR;
  logic [3:0]  SRAM0WREN;
  logic [31:0] SRAM0WDATA;
  logic        SRAM0CS;

  m3ds_ahb_sram_initiator #(.AW(15)) dut (
    .SRAM0HCLK(SRAM0HCLK), .SRAMHRESETn(SRAMHRESETn),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .SRAM0RDATA(SRAM0RDATA), .SRAM0ADDR(SRAM0ADDR),
    .SRAM0WREN(SRAM0WREN), .SRAM0WDATA(SRAM0WDATA), .SRAM0CS(SRAM0CS)
  );

  always #5 SRAM0HCLK = ~SRAM0HCLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [12:0] addr;
    logic [3:0]  wren;
    logic [31:0] data;
  } wr_t;
  wr_t wlog[$];

  logic [31:0] sram_mem [8192] = '{default: '0};
  logic [31:0] ref_mem  [8192] = '{default: '0};
  logic [31:0] exp_q[$];

  // SRAM bank model: registered read, byte-masked write, every write logged.
  always @(posedge SRAM0HCLK) begin
    if (SRAM0CS) begin
      if (SRAM0WREN != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (SRAM0WREN[b]) sram_mem[SRAM0ADDR][8*b +: 8] <= SRAM0WDATA[8*b +: 8];
        wlog.push_back('{SRAM0ADDR, SRAM0WREN, SRAM0WDATA});
      end else begin
        SRAM0RDATA <= sram_mem[SRAM0ADDR];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] lanes(input logic [2:0] size, input logic [14:0] addr);
    int nb = (size >= 3'd2) ? 4 : (1 << size);
    int lo = (int'(addr[1:0]) / nb) * nb;
    return 4'(((1 << nb) - 1) << lo);
  endfunction

  // Bench-side bus state
  bit          run_mon = 0;
  bit          rd_dp = 0, cur_read = 0;
  bit          dp_wr = 0;
  logic [12:0] dp_word;
  logic [3:0]  dp_mask;
  logic [31:0] dp_data;

  task automatic cyc(input bit sel, input bit rdy, input bit [1:0] trans, input bit wr,
                     input logic [14:0] addr, input logic [2:0] size, input logic [31:0] wd);
    bit a;
    HSEL = sel; HREADY = rdy; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
    HWDATA = dp_wr ? dp_data : $urandom;
    if (dp_wr)
      for (int b = 0; b < 4; b++)
        if (dp_mask[b]) ref_mem[dp_word][8*b +: 8] = dp_data[8*b +: 8];
    a = sel & rdy & trans[1];
    cur_read = a & ~wr;
    if (a & ~wr) exp_q.push_back(ref_mem[addr[14:2]]);
    @(posedge SRAM0HCLK);
    #1;
    rd_dp   = a & ~wr;
    dp_wr   = a & wr;
    dp_word = addr[14:2];
    dp_mask = lanes(size, addr);
    dp_data = wd;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 15'h0, 3'd0, 32'h0);
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [12:0] a,
                         input logic [3:0] we, input logic [31:0] d);
    if (idx >= wlog.size()) chk({nm, "_present"}, 32'(wlog.size()), 32'(idx + 1));
    else begin
      chk({nm, "_addr"}, 32'(wlog[idx].addr), 32'(a));
      chk({nm, "_wren"}, 32'(wlog[idx].wren), 32'(we));
      chk({nm, "_data"}, wlog[idx].data, d);
    end
  endtask

  // Monitor: pops the scoreboard in each read data phase; checks bus invariants each cycle.
  always @(negedge SRAM0HCLK) begin
    if (run_mon) begin
      if (rd_dp) begin
        if (exp_q.size() == 0) chk("hrdata_unexpected", HRDATA, 32'h0);
        else chk("hrdata", HRDATA, exp_q.pop_front());
      end
      if (cur_read) chk("no_write_in_read_aphase", 32'(SRAM0CS && SRAM0WREN != 4'b0000), 32'd0);
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) chk("hreadyout_hresp", {30'd0, HREADYOUT, HRESP}, 32'd2);
    end
  end

  int n0;
  logic [14:0] ra;
  logic [2:0]  rs;
  int          kind;

  initial begin
    // T1: reset with an active read presented on the bus
    SRAMHRESETn = 1'b0;
    HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 15'h0010;
    HSIZE = 3'd2; HWDATA = 32'h0; SRAM0RDATA = 32'h0;
    #3;
    chk("rst_cs", 32'(SRAM0CS), 32'd0);
    chk("rst_wren", 32'(SRAM0WREN), 32'd0);
    chk("rst_addr", 32'(SRAM0ADDR), 32'd0);
    chk("rst_wdata", SRAM0WDATA, 32'd0);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, SRAM0RDATA);
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (2) @(posedge SRAM0HCLK);
    #1 SRAMHRESETn = 1'b1;
    run_mon = 1;

    // T2: word write, two idles, single commit, then readback
    n0 = wlog.size();
    cyc(1, 1, 2'b10, 1, 15'h0010, 3'd2, 32'h1234_5678);
    idle();
    chk("t2_no_early_write", 32'(wlog.size()), 32'(n0));
    idle();
    chk("t2_one_write", 32'(wlog.size()), 32'(n0 + 1));
    chk_log("t2", n0, 13'h004, 4'hF, 32'h1234_5678);
    cyc(1, 1, 2'b10, 0, 15'h0010, 3'd2, 32'h0);
    idle();

    // T3: byte write then immediate read of the same word
    cyc(1, 1, 2'b10, 1, 15'h0010, 3'd2, 32'h1111_1111);
    idle(); idle();
    cyc(1, 1, 2'b10, 1, 15'h0013, 3'd0, 32'hAB00_0000);
    cyc(1, 1, 2'b10, 0, 15'h0010, 3'd2, 32'h0);
    idle(); idle();

    // T4: halfword write held across 8 reads, committed on the first idle cycle
    n0 = wlog.size();
    cyc(1, 1, 2'b10, 1, 15'h0022, 3'd1, 32'hBEEF_0000);
    for (int i = 0; i < 8; i++) cyc(1, 1, 2'b10, 0, 15'(15'h0100 + 4 * i), 3'd2, 32'h0);
    chk("t4_held", 32'(wlog.size()), 32'(n0));
    idle();
    chk_log("t4", n0, 13'h008, 4'b1100, 32'hBEEF_0000);
    idle();

    // T5: back-to-back writes commit in order
    n0 = wlog.size();
    cyc(1, 1, 2'b10, 1, 15'h0000, 3'd2, 32'hA5A5_0001);
    cyc(1, 1, 2'b10, 1, 15'h0004, 3'd2, 32'h5A5A_0002);
    idle(); idle();
    chk_log("t5_first", n0, 13'h000, 4'hF, 32'hA5A5_0001);
    chk_log("t5_second", n0 + 1, 13'h001, 4'hF, 32'h5A5A_0002);
    cyc(1, 1, 2'b10, 0, 15'h0000, 3'd2, 32'h0);
    cyc(1, 1, 2'b10, 0, 15'h0004, 3'd2, 32'h0);
    idle();

    // T6: reset during a write data phase discards the write
    cyc(1, 1, 2'b10, 1, 15'h0030, 3'd2, 32'hDEAD_BEEF);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
    #2 SRAMHRESETn = 1'b0;
    run_mon = 0;
    #1 chk("t6_rst_cs", 32'(SRAM0CS), 32'd0);
    repeat (2) @(posedge SRAM0HCLK);
    #1 SRAMHRESETn = 1'b1;
    dp_wr = 0; rd_dp = 0; cur_read = 0;
    run_mon = 1;
    n0 = wlog.size();
    repeat (4) idle();
    chk("t6_no_write", 32'(wlog.size()), 32'(n0));
    cyc(1, 1, 2'b10, 0, 15'h0030, 3'd2, 32'h0);
    idle();

    // Randomized traffic over a small window of words to provoke hits and merges
    for (int i = 0; i < 600; i++) begin
      kind = $urandom_range(0, 9);
      rs = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      ra = 15'(15'h0040 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
      if (rs == 3'd1) ra[0] = 1'b0;
      if (rs >= 3'd2) ra[1:0] = 2'b00;
      if (kind < 4) cyc(1, 1, 2'b10, 0, ra, rs, 32'h0);
      else if (kind < 8) cyc(1, 1, 2'($urandom_range(2, 3)), 1, ra, rs, $urandom);
      else if (kind == 8) cyc(0, 1, 2'b10, $urandom_range(0, 1) == 1, ra, rs, $urandom);
      else cyc(1, dp_wr ? 1'b1 : 1'b0, dp_wr ? 2'b00 : 2'b10, $urandom_range(0, 1) == 1, ra, rs, $urandom);
    end
    repeat (3) idle();
    for (int w = 16; w < 24; w++) chk("sram_vs_model", sram_mem[w], ref_mem[w]);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    run_mon = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
